// File: rtl/rv32_hart_pc_sched.sv
// rv32_hart_pc_sched: per-hart PC file with round-robin fetch offer and retire/redirect.
// Define RV32_SCHED_MISALIGN_CHK_EN to fault harts redirected to a misaligned target.
module rv32_hart_pc_sched #(
  parameter int unsigned NUM_HARTS = 8,
  parameter int unsigned HID_W = $clog2(NUM_HARTS),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sched_en_i,
  input  logic [NUM_HARTS-1:0] hart_halt_i,
  output logic                 fetch_valid_o,
  output logic [HID_W-1:0]     fetch_hart_o,
  output logic [31:0]          fetch_pc_o,
  input  logic                 fetch_ready_i,
  input  logic                 wb_valid_i,
  input  logic [HID_W-1:0]     wb_hart_i,
  input  logic                 wb_has_new_pc_i,
  input  logic [31:0]          wb_next_pc_i,
  output logic [NUM_HARTS-1:0] inflight_mask_o,
  output logic                 err_spurious_o,
  output logic                 err_misalign_o
);
  typedef enum logic [1:0] {H_IDLE, H_INFLIGHT, H_FAULT} hart_st_e;
  typedef enum logic {S_EMPTY, S_OFFER} fsm_e;

  hart_st_e         st_q [NUM_HARTS];
  hart_st_e         st_d [NUM_HARTS];
  logic [29:0]      pc_q [NUM_HARTS];
  logic [29:0]      pc_d [NUM_HARTS];
  fsm_e             fsm_q, fsm_d;
  logic [HID_W-1:0] hart_q, hart_d, last_q, last_d, start, pick;
  logic [29:0]      fpc_q, fpc_d;
  logic             spur_q, spur_d;
  logic             accept, retire, any_elig, load;
  logic [NUM_HARTS-1:0] elig;

  assign accept = fsm_q == S_OFFER && fetch_ready_i;
  assign retire = wb_valid_i && st_q[wb_hart_i] == H_INFLIGHT;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign elig[h] = st_q[h] == H_IDLE && !hart_halt_i[h] && !(accept && hart_q == HID_W'(h));
    assign inflight_mask_o[h] = st_q[h] == H_INFLIGHT;
  end

  // Downward scan so the smallest offset from start wins.
  always_comb begin
    start = (accept ? hart_q : last_q) + HID_W'(1);
    pick = start;
    any_elig = 1'b0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (elig[start + HID_W'(i)]) begin
        pick = start + HID_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign load = (fsm_q == S_EMPTY || accept) && sched_en_i && any_elig;

  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    fsm_d = load ? S_OFFER : (accept ? S_EMPTY : fsm_q);
    hart_d = load ? pick : hart_q;
    fpc_d = load ? pc_q[pick] : fpc_q;
    last_d = accept ? hart_q : last_q;
    spur_d = spur_q | (wb_valid_i && !retire);
    if (retire) begin
      pc_d[wb_hart_i] = wb_has_new_pc_i ? wb_next_pc_i[31:2] : pc_q[wb_hart_i] + 30'd1;
      st_d[wb_hart_i] = H_IDLE;
`ifdef RV32_SCHED_MISALIGN_CHK_EN
      if (wb_has_new_pc_i && |wb_next_pc_i[1:0]) st_d[wb_hart_i] = H_FAULT;
`endif
    end
    if (accept) st_d[hart_q] = H_INFLIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        st_q[i] <= H_IDLE;
        pc_q[i] <= RESET_PC[31:2];
      end
      fsm_q <= S_EMPTY;
      hart_q <= '0;
      last_q <= HID_W'(NUM_HARTS - 1);
      fpc_q <= RESET_PC[31:2];
      spur_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
      fsm_q <= fsm_d;
      hart_q <= hart_d;
      last_q <= last_d;
      fpc_q <= fpc_d;
      spur_q <= spur_d;
    end
  end

`ifdef RV32_SCHED_MISALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else mis_q <= mis_q | (retire && wb_has_new_pc_i && |wb_next_pc_i[1:0]);
  end
  assign err_misalign_o = mis_q;
`else
  logic unused_lo;
  assign unused_lo = ^wb_next_pc_i[1:0];
  assign err_misalign_o = 1'b0;
`endif

  assign fetch_valid_o = fsm_q == S_OFFER;
  assign fetch_hart_o = hart_q;
  assign fetch_pc_o = {fpc_q, 2'b00};
  assign err_spurious_o = spur_q;
endmodule

// File: tb/tb_rv32_hart_pc_sched.sv
// tb_rv32_hart_pc_sched: directed scenarios checked against a spec-level model every cycle,
// plus hand-computed literal expectations at key points.
module tb_rv32_hart_pc_sched;
  localparam int N = 8;
  localparam int HW = 3;

  logic clk = 1'b0, rst_n = 1'b1, sched_en = 1'b0, fetch_ready = 1'b0;
  logic wb_valid = 1'b0, wb_has_new_pc = 1'b0;
  logic [N-1:0] hart_halt = '0;
  logic [HW-1:0] wb_hart = '0;
  logic [31:0] wb_next_pc = '0;
  logic fetch_valid, err_spurious, err_misalign;
  logic [HW-1:0] fetch_hart;
  logic [31:0] fetch_pc;
  logic [N-1:0] inflight_mask;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  rv32_hart_pc_sched #(.NUM_HARTS(N), .HID_W(HW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en_i(sched_en), .hart_halt_i(hart_halt),
    .fetch_valid_o(fetch_valid), .fetch_hart_o(fetch_hart), .fetch_pc_o(fetch_pc),
    .fetch_ready_i(fetch_ready), .wb_valid_i(wb_valid), .wb_hart_i(wb_hart),
    .wb_has_new_pc_i(wb_has_new_pc), .wb_next_pc_i(wb_next_pc),
    .inflight_mask_o(inflight_mask), .err_spurious_o(err_spurious), .err_misalign_o(err_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: hart state 0=idle 1=inflight 2=fault, plus the pending offer.
  int ms [N];
  logic [31:0] mpc [N];
  int mlast, mh;
  bit mv, mspur, mmis;
  logic [31:0] mfpc;

  task automatic model_reset();
    for (int h = 0; h < N; h++) begin
      ms[h] = 0;
      mpc[h] = 32'h0;
    end
    mlast = N - 1;
    mh = 0;
    mv = 0;
    mfpc = 32'h0;
    mspur = 0;
    mmis = 0;
  endtask

  task automatic model_step();
    bit acc, el[N];
    int acc_h, pick, c;
    acc = mv && fetch_ready;
    acc_h = mh;
    for (int h = 0; h < N; h++) el[h] = ms[h] == 0 && !hart_halt[h] && !(acc && acc_h == h);
    if (acc) mlast = acc_h;
    pick = -1;
    if (sched_en && (!mv || acc))
      for (int k = 0; k < N; k++) begin
        c = (mlast + 1 + k) % N;
        if (pick < 0 && el[c]) pick = c;
      end
    if (pick >= 0) begin
      mh = pick;
      mfpc = mpc[pick];
      mv = 1;
    end else if (acc) mv = 0;
    if (wb_valid) begin
      if (ms[wb_hart] == 1) begin
        mpc[wb_hart] = wb_has_new_pc ? (wb_next_pc & ~32'h3) : mpc[wb_hart] + 32'd4;
        ms[wb_hart] = 0;
`ifdef RV32_SCHED_MISALIGN_CHK_EN
        if (wb_has_new_pc && wb_next_pc[1:0] != 2'b00) begin
          ms[wb_hart] = 2;
          mmis = 1;
        end
`endif
      end else mspur = 1;
    end
    if (acc) ms[acc_h] = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [N-1:0] m;
      for (int h = 0; h < N; h++) m[h] = ms[h] == 1;
      chk("model fetch_valid", fetch_valid, mv);
      if (mv) begin
        chk("model fetch_hart", fetch_hart, mh);
        chk("model fetch_pc", fetch_pc, mfpc);
      end
      chk("model inflight_mask", inflight_mask, m);
      chk("model err_spurious", err_spurious, mspur);
      chk("model err_misalign", err_misalign, mmis);
    end
  end

  task automatic retire(input int h, input bit nw, input logic [31:0] tgt);
    wb_valid = 1'b1;
    wb_hart = HW'(h);
    wb_has_new_pc = nw;
    wb_next_pc = tgt;
    @(negedge clk);
    wb_valid = 1'b0;
    wb_has_new_pc = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #20;
    chk("reset fetch_valid", fetch_valid, 0);
    chk("reset fetch_hart", fetch_hart, 0);
    chk("reset fetch_pc", fetch_pc, 32'h0);
    chk("reset inflight", inflight_mask, 8'h00);
    chk("reset err_spurious", err_spurious, 0);
    chk("reset err_misalign", err_misalign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sched_en = 1'b1;
    fetch_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("b2b valid", fetch_valid, 1);
      chk("b2b hart", fetch_hart, i);
      chk("b2b pc", fetch_pc, 32'h0);
      @(negedge clk);
    end
    chk("all issued valid", fetch_valid, 0);
    chk("all issued inflight", inflight_mask, 8'hFF);

    retire(3, 0, 32'h0);
    chk("retire3 same-cycle valid", fetch_valid, 0);
    chk("retire3 inflight", inflight_mask, 8'hF7);
    @(negedge clk);
    chk("retire3 offer valid", fetch_valid, 1);
    chk("retire3 offer hart", fetch_hart, 3);
    chk("retire3 offer pc", fetch_pc, 32'h4);
    @(negedge clk);
    chk("retire3 accepted", inflight_mask, 8'hFF);

    fetch_ready = 1'b0;
    retire(5, 1, 32'h100);
    @(negedge clk);
    chk("redirect5 hart", fetch_hart, 5);
    chk("redirect5 pc", fetch_pc, 32'h100);
    hart_halt[5] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall valid", fetch_valid, 1);
      chk("stall hart", fetch_hart, 5);
      chk("stall pc", fetch_pc, 32'h100);
    end
    retire(2, 0, 32'h0);
    retire(2, 0, 32'h0);
    chk("spurious flag", err_spurious, 1);
    chk("spurious offer hart", fetch_hart, 5);
    chk("spurious offer pc", fetch_pc, 32'h100);
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("after spurious hart", fetch_hart, 2);
    chk("after spurious pc", fetch_pc, 32'h4);
    @(negedge clk);
    hart_halt[5] = 1'b0;
    chk("drain valid", fetch_valid, 0);
    chk("drain inflight", inflight_mask, 8'hFF);

    retire(1, 1, 32'h102);
    @(negedge clk);
`ifdef RV32_SCHED_MISALIGN_CHK_EN
    chk("misalign valid", fetch_valid, 0);
    chk("misalign flag", err_misalign, 1);
    chk("misalign inflight", inflight_mask, 8'hFD);
`else
    chk("misalign valid", fetch_valid, 1);
    chk("misalign hart", fetch_hart, 1);
    chk("misalign pc", fetch_pc, 32'h100);
    chk("misalign flag", err_misalign, 0);
`endif
    @(negedge clk);
    chk("misalign drain valid", fetch_valid, 0);

    fetch_ready = 1'b0;
    retire(0, 0, 32'h0);
    retire(4, 0, 32'h0);
    retire(6, 0, 32'h0);
    retire(7, 0, 32'h0);
    chk("pre-reset offer valid", fetch_valid, 1);
    chk("pre-reset offer hart", fetch_hart, 0);
    chk("pre-reset offer pc", fetch_pc, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", fetch_valid, 0);
    chk("async reset inflight", inflight_mask, 8'h00);
    chk("async reset err_spurious", err_spurious, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset valid", fetch_valid, 1);
    chk("post-reset hart", fetch_hart, 0);
    chk("post-reset pc", fetch_pc, 32'h0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv32_hart_pc_sched.md
# rv32_hart_pc_sched

Per-hart program-counter file and round-robin fetch scheduler for the barrel-threaded RV32 core. It holds one PC per hart and offers a (hart, PC) fetch request to the fetch stage through a valid/ready handshake. It retires each hart's instruction using the next-PC unit's `has_new_pc` / `next_pc_val` result, and re-enables that hart for scheduling. At most one instruction per hart is in flight at any time.

## Interface
- `NUM_HARTS`, default 8: number of harts; a power of 2, at least 2.
- `HID_W`, default `$clog2(NUM_HARTS)`: width of the hart id.
- `RESET_PC`, default 32'h0000_0000: PC loaded into every hart on reset.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `sched_en`  in  1  global run enable; when low, no new offer is started.
- `hart_halt`  in  NUM_HARTS  per-hart halt mask; a halted hart is not eligible.
- `fetch_valid`  out  1  fetch offer valid.
- `fetch_hart`  out  HID_W  hart id of the offered fetch.
- `fetch_pc`  out  32  PC of the offered fetch; bits [1:0] are always 0.
- `fetch_ready`  in  1  fetch stage accepts the offer.
- `wb_valid`  in  1  retire strobe from the next-PC stage.
- `wb_hart`  in  HID_W  hart id of the retiring instruction.
- `wb_has_new_pc`  in  1  redirect flag from the next-PC unit.
- `wb_next_pc`  in  32  redirect target; used only when `wb_has_new_pc`=1.
- `inflight_mask`  out  NUM_HARTS  bit h=1 while hart h is between offer accept and retire.
- `err_spurious`  out  1  sticky; set by a retire for a hart that is not in flight.
- `err_misalign`  out  1  sticky; see Configuration.

## Operation
- Per-hart state is IDLE, INFLIGHT or FAULT. FAULT exists only with the macro.
- A hart is eligible when it is IDLE, not halted, and not the hart whose offer is being accepted this cycle.
- Offer FSM:
  - EMPTY: if `sched_en`=1 and an eligible hart exists, pick one and go to OFFER.
  - OFFER: `fetch_valid`=1. On `fetch_ready`=1:
    - the offered hart goes to INFLIGHT;
    - if `sched_en`=1 and another hart is eligible, load the next pick and stay in OFFER;
    - otherwise go to EMPTY.
- Pick rule: round-robin. The search starts at (last accepted hart + 1) mod NUM_HARTS and takes the lowest index at or after the start, with wrap. After reset the last accepted hart is NUM_HARTS-1, so hart 0 is picked first.
- The offer is never retracted. `fetch_hart` and `fetch_pc` stay stable until accepted, even if `sched_en` drops or the offered hart becomes halted.
- Retire, when `wb_valid`=1 and `wb_hart` is INFLIGHT:
  - PC[h] becomes {`wb_next_pc`[31:2],2'b00} if `wb_has_new_pc`=1, otherwise PC[h]+4;
  - the +4 increment wraps modulo 2^32 (32'hFFFF_FFFC goes to 0);
  - the hart goes back to IDLE.
- Retire for a hart that is not INFLIGHT: ignored, PC unchanged, `err_spurious` is set.
- A retire and an accept for different harts in the same cycle are both applied. The retire and the accept cannot target the same hart, because an INFLIGHT hart is never offered.
- A retired hart is eligible from the next cycle, not in the retire cycle.

## Timing
- Reset values:
  - `fetch_valid`=0, `fetch_hart`=0, `fetch_pc`=RESET_PC;
  - `inflight_mask`=0, both error flags 0;
  - every PC = RESET_PC, every hart IDLE, FSM in EMPTY.
- Reset during an offer or while harts are in flight drops `fetch_valid` immediately (asynchronous) and discards all in-flight state.
- Every output is registered; no combinational path from any input to any output.
- From EMPTY: first `fetch_valid` goes high one cycle after the edge that sees `sched_en`=1 and an eligible hart.
- Back-to-back issue: one accept per cycle while at least 2 harts are eligible. With one eligible hart, issue is one accept every 2 cycles.
- A hart's PC update is visible in `fetch_pc` no earlier than 1 cycle after its retire.

## Configuration
- `RV32_SCHED_MISALIGN_CHK_EN` defined:
  - a retire with `wb_has_new_pc`=1 and `wb_next_pc`[1:0]≠0 sets `err_misalign`;
  - it moves the hart to FAULT; PC[h] is loaded with the aligned target;
  - a FAULT hart is never eligible again until reset.
- `RV32_SCHED_MISALIGN_CHK_EN` undefined: low bits are silently cleared, `err_misalign` is tied to 0, and no FAULT state exists.

## Test plan
- Reset, `sched_en`=1, `fetch_ready`=1, no retires, NUM_HARTS=8 -> 8 consecutive accepts of harts 0..7, all with PC 0x0. Then `fetch_valid`=0 and `inflight_mask`=8'hFF.
- From that state, retire hart 3 with `wb_has_new_pc`=0 -> next offer is hart 3, PC 0x4; the offer appears 2 cycles after the retire edge.
- Retire hart 5 with `wb_has_new_pc`=1 and `wb_next_pc`=0x100 -> hart 5 is offered with PC 0x100. With `fetch_ready`=0 held for 5 cycles, `fetch_hart`/`fetch_pc` stay stable while `hart_halt`[5] is raised.
- `wb_valid` for hart 2 while hart 2 is IDLE -> `err_spurious`=1, PC[2] unchanged, no change to the offer.
- With the macro: retire hart 1 with `wb_has_new_pc`=1 and `wb_next_pc`=0x102 -> `err_misalign`=1 and hart 1 is never offered again. Without the macro: hart 1 is offered at 0x100.
- Assert `rst_n`=0 mid-offer with 4 harts in flight -> `fetch_valid`=0 and `inflight_mask`=0 immediately. After release, the next offer is hart 0 with PC RESET_PC.
